// File: rtl/btb_update_queue_pkg.sv
// Shared types and sizing constants for the BTB update queue.
package btb_update_queue_pkg;

  localparam int ADDR_W           = 32;
  localparam int BTB_UQ_DEPTH     = 4;
  localparam int BTB_UQ_DROP_BITS = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef struct packed {
    addr_t branch_pc;
    addr_t target_pc;
  } btb_update_entry_t;

endpackage

// File: rtl/btb_update_queue_if.sv
// Resolution lanes in, serialized BTB training port and status out.
interface btb_update_queue_if
  import btb_update_queue_pkg::*;
#(
  parameter int RESOLVE_WIDTH = 2
) ();

  logic [RESOLVE_WIDTH-1:0]         in_valid;
  logic [RESOLVE_WIDTH-1:0]         in_taken;
  addr_t [RESOLVE_WIDTH-1:0]        in_branch_PC;
  addr_t [RESOLVE_WIDTH-1:0]        in_target_PC;
  logic                             resolving_valid;
  addr_t                            resolving_branch_PC;
  addr_t                            resolving_target_PC;
  logic                             empty;
  logic                             full;
  logic [BTB_UQ_DROP_BITS-1:0]      drop_count;

  modport master (
    output in_valid, in_taken, in_branch_PC, in_target_PC,
    input  resolving_valid, resolving_branch_PC, resolving_target_PC,
    input  empty, full, drop_count
  );

  modport slave (
    input  in_valid, in_taken, in_branch_PC, in_target_PC,
    output resolving_valid, resolving_branch_PC, resolving_target_PC,
    output empty, full, drop_count
  );

endinterface

// File: rtl/btb_uq_match.sv
// Combinational CAM: lane PCs against live queue entries, plus intra-cycle duplicates.
module btb_uq_match
  import btb_update_queue_pkg::*;
#(
  parameter int RESOLVE_WIDTH = 2,
  parameter int DEPTH         = 4
) (
  input  logic [RESOLVE_WIDTH-1:0]              cand,
  input  addr_t [RESOLVE_WIDTH-1:0]             cand_pc,
  input  addr_t [DEPTH-1:0]                     entry_pc,
  input  logic [DEPTH-1:0]                      entry_live,
  output logic [RESOLVE_WIDTH-1:0][DEPTH-1:0]   hit,
  output logic [RESOLVE_WIDTH-1:0]              dup
);

  // dup[i]: an earlier lane already carries this PC, so lane i folds into it
  always_comb begin
    hit = '0;
    dup = '0;
    for (int i = 0; i < RESOLVE_WIDTH; i++) begin
      for (int k = 0; k < DEPTH; k++)
        hit[i][k] = cand[i] && entry_live[k] && (cand_pc[i] == entry_pc[k]);
      for (int j = 0; j < i; j++)
        if (cand[i] && cand[j] && (cand_pc[i] == cand_pc[j]))
          dup[i] = 1'b1;
    end
  end

endmodule

// File: rtl/btb_update_queue.sv
// Coalescing queue of taken-branch outcomes, drained one BTB write per cycle.
module btb_update_queue
  import btb_update_queue_pkg::*;
#(
  parameter int RESOLVE_WIDTH = 2,
  parameter int DEPTH         = BTB_UQ_DEPTH
) (
  input  logic               clock,
  input  logic               reset,
  btb_update_queue_if.slave  bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int DROP_W = BTB_UQ_DROP_BITS;

  logic [PTR_W-1:0]                     head, tail;
  logic [CNT_W-1:0]                     count;
  logic [DROP_W-1:0]                    drop_cnt;
  btb_update_entry_t [DEPTH-1:0]        entry_q;

  logic                                 deq;
  logic [RESOLVE_WIDTH-1:0]             cand, leader, alloc, dup;
  logic [RESOLVE_WIDTH-1:0][DEPTH-1:0]  hit;
  addr_t [RESOLVE_WIDTH-1:0]            merged_tgt;
  logic [PTR_W-1:0]                     slot [RESOLVE_WIDTH];
  logic [DEPTH-1:0]                     live;
  addr_t [DEPTH-1:0]                    entry_pc;
  int                                   n_alloc, n_drop, free_slots;

  function automatic logic [DROP_W-1:0] sat_drop(input logic [DROP_W-1:0] cur, input int n);
    logic [DROP_W:0] sum;
    sum = {1'b0, cur} + (DROP_W+1)'(n);
    return sum[DROP_W] ? '1 : sum[DROP_W-1:0];
  endfunction

  function automatic logic [PTR_W-1:0] offset_of(input int k, input logic [PTR_W-1:0] h);
    return PTR_W'(k) - h;
  endfunction

  assign deq  = (count != '0);
  assign cand = bus.in_valid & bus.in_taken;

  // The head leaves this cycle, so only offsets 1..count-1 may absorb an update
  always_comb begin
    live     = '0;
    entry_pc = '0;
    for (int k = 0; k < DEPTH; k++) begin
      entry_pc[k] = entry_q[k].branch_pc;
      live[k]     = (offset_of(k, head) != '0) && (CNT_W'(offset_of(k, head)) < count);
    end
  end

  btb_uq_match #(
    .RESOLVE_WIDTH (RESOLVE_WIDTH),
    .DEPTH         (DEPTH)
  ) u_match (
    .cand       (cand),
    .cand_pc    (bus.in_branch_PC),
    .entry_pc   (entry_pc),
    .entry_live (live),
    .hit        (hit),
    .dup        (dup)
  );

  // First lane of a PC owns the slot; the last lane with that PC supplies the target
  always_comb begin
    n_alloc    = 0;
    n_drop     = 0;
    alloc      = '0;
    leader     = '0;
    merged_tgt = '0;
    free_slots = DEPTH - int'(count) + (deq ? 1 : 0);
    for (int i = 0; i < RESOLVE_WIDTH; i++) begin
      slot[i]       = '0;
      merged_tgt[i] = bus.in_target_PC[i];
      for (int j = i + 1; j < RESOLVE_WIDTH; j++)
        if (cand[j] && (bus.in_branch_PC[j] == bus.in_branch_PC[i]))
          merged_tgt[i] = bus.in_target_PC[j];
      leader[i] = cand[i] && !dup[i];
      if (leader[i] && (hit[i] == '0)) begin
        if (n_alloc < free_slots) begin
          alloc[i] = 1'b1;
          slot[i]  = tail + PTR_W'(n_alloc);
          n_alloc  = n_alloc + 1;
        end else begin
          n_drop = n_drop + 1;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else begin
      head     <= head + PTR_W'(deq);
      tail     <= tail + PTR_W'(n_alloc);
      count    <= count - CNT_W'(deq) + CNT_W'(n_alloc);
      drop_cnt <= sat_drop(drop_cnt, n_drop);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < RESOLVE_WIDTH; i++) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (leader[i] && hit[i][k])
          entry_q[k].target_pc <= merged_tgt[i];
        if (alloc[i] && (slot[i] == PTR_W'(k)))
          entry_q[k] <= '{branch_pc: bus.in_branch_PC[i], target_pc: merged_tgt[i]};
      end
    end
  end

  // Payload is not cleared by reset, so gate it while the queue is empty
  assign bus.resolving_valid     = deq;
  assign bus.resolving_branch_PC = deq ? entry_q[head].branch_pc : '0;
  assign bus.resolving_target_PC = deq ? entry_q[head].target_pc : '0;
  assign bus.empty               = (count == '0);
  assign bus.full                = (count == CNT_W'(DEPTH));
  assign bus.drop_count          = drop_cnt;

endmodule

// File: tb/tb_btb_update_queue.sv
// Randomized bench for btb_update_queue against a queue-based reference model.
module tb_btb_update_queue;
  import btb_update_queue_pkg::*;

  localparam int RW = 2;
  localparam int DP = 4;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] tgt;
  } ent_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;
  ent_t mq[$];
  int   mdrop = 0;

  btb_update_queue_if #(.RESOLVE_WIDTH(RW)) bus ();

  btb_update_queue #(.RESOLVE_WIDTH(RW), .DEPTH(DP)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_lane(input int i, input logic v, input logic t,
                          input logic [31:0] pc, input logic [31:0] tg);
    bus.in_valid[i]     = v;
    bus.in_taken[i]     = t;
    bus.in_branch_PC[i] = pc;
    bus.in_target_PC[i] = tg;
  endtask

  task automatic idle();
    for (int i = 0; i < RW; i++) set_lane(i, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  // Reference: drain head, fold lanes into unique PCs (first position, last target),
  // then update surviving entries in place or append while room remains.
  task automatic model_step();
    logic [31:0] upc[$];
    logic [31:0] utg[$];
    bit found;
    if (mq.size() > 0) void'(mq.pop_front());
    for (int i = 0; i < RW; i++) begin
      if (bus.in_valid[i] && bus.in_taken[i]) begin
        found = 0;
        foreach (upc[u]) if (upc[u] == bus.in_branch_PC[i]) begin utg[u] = bus.in_target_PC[i]; found = 1; end
        if (!found) begin upc.push_back(bus.in_branch_PC[i]); utg.push_back(bus.in_target_PC[i]); end
      end
    end
    foreach (upc[u]) begin
      found = 0;
      foreach (mq[k]) if (mq[k].pc == upc[u]) begin mq[k].tgt = utg[u]; found = 1; end
      if (!found) begin
        if (mq.size() < DP) mq.push_back('{pc: upc[u], tgt: utg[u]});
        else if (mdrop < 65535) mdrop++;
      end
    end
  endtask

  task automatic check_outputs();
    chk("valid", 32'(bus.resolving_valid), 32'(mq.size() != 0));
    chk("branch_pc", bus.resolving_branch_PC, (mq.size() != 0) ? mq[0].pc : 32'h0);
    chk("target_pc", bus.resolving_target_PC, (mq.size() != 0) ? mq[0].tgt : 32'h0);
    chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
    chk("full", 32'(bus.full), 32'(mq.size() == DP));
    chk("drop_count", 32'(bus.drop_count), 32'(mdrop));
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  // Pull reset between edges and confirm the outputs clear without a clock edge
  task automatic async_reset_check();
    #2 reset = 1'b0;
    #1;
    chk("rst_valid", 32'(bus.resolving_valid), 32'h0);
    chk("rst_branch_pc", bus.resolving_branch_PC, 32'h0);
    chk("rst_target_pc", bus.resolving_target_PC, 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'h1);
    chk("rst_full", 32'(bus.full), 32'h0);
    chk("rst_drop", 32'(bus.drop_count), 32'h0);
    mq.delete();
    mdrop = 0;
    #1 reset = 1'b1;
  endtask

  initial begin
    idle();
    repeat (2) @(negedge clock);
    check_outputs();
    reset = 1'b1;
    @(negedge clock);

    // Single lane, one-cycle latency, then drains
    set_lane(0, 1'b1, 1'b1, 32'h100, 32'h200);
    cycle();
    chk("one_valid", 32'(bus.resolving_valid), 32'h1);
    chk("one_pc", bus.resolving_branch_PC, 32'h100);
    chk("one_tgt", bus.resolving_target_PC, 32'h200);
    idle();
    cycle();
    chk("one_empty", 32'(bus.empty), 32'h1);

    // Not-taken lane is ignored
    set_lane(0, 1'b1, 1'b0, 32'h140, 32'h180);
    cycle();
    chk("nt_valid", 32'(bus.resolving_valid), 32'h0);
    idle();

    // Same PC on both lanes: one entry with the later target
    set_lane(0, 1'b1, 1'b1, 32'h300, 32'h400);
    set_lane(1, 1'b1, 1'b1, 32'h300, 32'h480);
    cycle();
    chk("dup_tgt", bus.resolving_target_PC, 32'h480);
    idle();
    cycle();
    chk("dup_single", 32'(bus.empty), 32'h1);

    // Coalesce into a non-head entry
    set_lane(0, 1'b1, 1'b1, 32'h0FC, 32'h1);
    set_lane(1, 1'b1, 1'b1, 32'h100, 32'h2);
    cycle();
    set_lane(0, 1'b1, 1'b1, 32'h104, 32'h3);
    set_lane(1, 1'b1, 1'b1, 32'h108, 32'h4);
    cycle();
    chk("cq_head", bus.resolving_branch_PC, 32'h100);
    idle();
    set_lane(0, 1'b1, 1'b1, 32'h108, 32'h900);
    cycle();
    idle();
    cycle();
    chk("cq_pc", bus.resolving_branch_PC, 32'h108);
    chk("cq_tgt", bus.resolving_target_PC, 32'h900);
    cycle();
    chk("cq_drained", 32'(bus.empty), 32'h1);

    // Async reset with three entries queued
    set_lane(0, 1'b1, 1'b1, 32'h0FC, 32'h1);
    set_lane(1, 1'b1, 1'b1, 32'h100, 32'h2);
    cycle();
    set_lane(0, 1'b1, 1'b1, 32'h104, 32'h3);
    set_lane(1, 1'b1, 1'b1, 32'h108, 32'h4);
    cycle();
    idle();
    async_reset_check();

    // Overflow: two new PCs per cycle; fills after 3 cycles, then one drop per cycle
    for (int c = 0; c < 6; c++) begin
      set_lane(0, 1'b1, 1'b1, 32'h1000 + 32'(c * 16), 32'h2000 + 32'(c));
      set_lane(1, 1'b1, 1'b1, 32'h1008 + 32'(c * 16), 32'h3000 + 32'(c));
      cycle();
      if (c == 2) chk("ovf_full", 32'(bus.full), 32'h1);
    end
    chk("ovf_drop", 32'(bus.drop_count), 32'h3);
    idle();
    repeat (5) cycle();

    // Random traffic over a small PC pool to provoke coalescing
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < RW; i++)
        set_lane(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 4) != 0),
                 32'h100 + 32'($urandom_range(0, 7) * 4), $urandom);
      cycle();
      if ($urandom_range(0, 99) == 0) begin
        idle();
        async_reset_check();
      end
    end
    idle();
    repeat (6) cycle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
